// File: rtl/dfr_readout.sv
// DFR readout layer: per-node weighted sum over a frame, scaled and emitted once per frame.
// Optional DFR_READOUT_SAT_EN clamps the scaled result to the signed DATA_WIDTH range.
module dfr_readout #(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHT_WIDTH  = 16,
    parameter int ACC_WIDTH     = 64,
    parameter int OUT_SHIFT     = 12,
    localparam int AW = $clog2(VIRTUAL_NODES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    sample_valid,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    w_wr_en,
    input  logic [AW-1:0]           w_addr,
    input  logic [WEIGHT_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    out_valid,
    output logic                    busy,
    output logic [AW-1:0]           node_idx
);

    localparam int PW = DATA_WIDTH + 1 + WEIGHT_WIDTH;
    localparam logic [AW:0] NODES = (AW+1)'(VIRTUAL_NODES);
    localparam logic [AW-1:0] LAST_IDX = AW'(VIRTUAL_NODES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t state, state_n;

    logic signed [WEIGHT_WIDTH-1:0] weight [VIRTUAL_NODES];

    logic                 accept;
    logic                 last_node;
    logic signed [PW-1:0] prod_c;

    logic                 p1_valid, p1_first, p1_last;
    logic signed [PW-1:0] p1_prod;

    logic                        p2_valid, p2_last;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]       result;

    assign accept    = sample_valid & ~clear;
    assign last_node = (node_idx == LAST_IDX);
    assign prod_c    = $signed({1'b0, din}) * weight[node_idx];
    assign busy      = (state != IDLE) | p1_valid | p2_valid;

    // Weight file is deliberately not reset; reads see the pre-write value.
    always_ff @(posedge clk) begin
        if (w_wr_en && ({1'b0, w_addr} < NODES))
            weight[w_addr] <= w_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = IDLE;
        end else if (accept) begin
            state_n = last_node ? FLUSH : ACCUM;
        end else begin
            case (state)
                FLUSH:   if (p1_valid && p1_last) state_n = IDLE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            node_idx <= '0;
            p1_valid <= 1'b0;
            p1_first <= 1'b0;
            p1_last  <= 1'b0;
            p1_prod  <= '0;
        end else begin
            p1_valid <= accept;
            if (clear)
                node_idx <= '0;
            else if (accept) begin
                node_idx <= last_node ? '0 : node_idx + 1'b1;
                p1_first <= (node_idx == '0);
                p1_last  <= last_node;
                p1_prod  <= prod_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            p2_valid <= 1'b0;
            p2_last  <= 1'b0;
        end else begin
            p2_valid <= p1_valid & ~clear;
            p2_last  <= p1_last;
            if (p1_valid && !clear)
                acc <= p1_first ? ACC_WIDTH'(p1_prod)
                                : acc + ACC_WIDTH'(p1_prod);
        end
    end

    assign shifted = acc >>> OUT_SHIFT;

`ifdef DFR_READOUT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

    always_comb begin
        result = shifted[DATA_WIDTH-1:0];
        if (shifted > MAX_V)
            result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (shifted < MIN_V)
            result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
`else
    assign result = shifted[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= p2_valid & p2_last & ~clear;
            if (p2_valid && p2_last && !clear)
                dout <= result;
        end
    end

endmodule

// File: tb/tb_dfr_readout.sv
// Randomised and directed bench for dfr_readout against a frame-level model.
// Honours DFR_READOUT_SAT_EN for the expected output scaling.
module tb_dfr_readout;

    localparam int VN = 4;
    localparam int OS = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] din = '0;
    logic        w_wr_en = 1'b0;
    logic [1:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic [31:0] dout;
    logic        out_valid;
    logic        busy;
    logic [1:0]  node_idx;

    dfr_readout #(
        .VIRTUAL_NODES(VN),
        .DATA_WIDTH(32),
        .WEIGHT_WIDTH(16),
        .ACC_WIDTH(64),
        .OUT_SHIFT(OS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .sample_valid(sample_valid),
        .din(din),
        .w_wr_en(w_wr_en),
        .w_addr(w_addr),
        .w_data(w_data),
        .dout(dout),
        .out_valid(out_valid),
        .busy(busy),
        .node_idx(node_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] val;
    } pend_t;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] wm [VN];
    pend_t  pend [$];
    int     k = 0;
    longint macc = 0;
    int     cyc = 0;
    bit     acc_prev = 0;
    logic [31:0] exp_dout = '0;
    bit     exp_busy = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] scale(input longint a);
        longint s;
        s = a >>> OS;
`ifdef DFR_READOUT_SAT_EN
        if (s > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic step(input logic sv, input logic [31:0] d,
                        input logic clr, input logic we,
                        input logic [1:0] wa, input logic [15:0] wd);
        bit     acc;
        longint p;
        bit     ov_exp;
        sample_valid = sv;
        din = d;
        clear = clr;
        w_wr_en = we;
        w_addr = wa;
        w_data = wd;
        @(posedge clk);
        cyc++;
        if (clr) begin
            pend.delete();
            k = 0;
        end
        acc = sv && !clr;
        if (acc) begin
            p = longint'(d) * longint'(wm[k]);
            macc = (k == 0) ? p : macc + p;
            if (k == VN - 1) pend.push_back('{cyc + 2, scale(macc)});
            k = (k == VN - 1) ? 0 : k + 1;
        end
        if (we && int'(wa) < VN) wm[wa] = wd;
        exp_busy = (k != 0) || acc || (acc_prev && !clr);
        acc_prev = acc;
        #1;
        ov_exp = (pend.size() != 0) && (pend[0].due == cyc);
        if (ov_exp) begin
            exp_dout = pend[0].val;
            void'(pend.pop_front());
        end
        check("out_valid", 64'(out_valid), 64'(ov_exp));
        check("dout", 64'(dout), 64'(exp_dout));
        check("busy", 64'(busy), 64'(exp_busy));
        check("node_idx", 64'(node_idx), 64'(k));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0);
    endtask

    task automatic sample(input logic [31:0] d);
        step(1, d, 0, 0, '0, '0);
    endtask

    task automatic load_w(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] e);
        step(0, '0, 0, 1, 2'd0, a);
        step(0, '0, 0, 1, 2'd1, b);
        step(0, '0, 0, 1, 2'd2, c);
        step(0, '0, 0, 1, 2'd3, e);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        pend.delete();
        k = 0;
        acc_prev = 0;
        exp_dout = '0;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_node_idx", 64'(node_idx), 64'd0);
        #1 rst = 1'b1;
    endtask

    initial begin
        #23;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_node_idx", 64'(node_idx), 64'd0);
        #5 rst = 1'b1;

        load_w(16'd1, 16'd2, 16'd3, 16'd4);
        sample(10); sample(20); sample(30); sample(40);
        idle(5);
        check("basic_300", 64'(dout), 64'd300);

        load_w(16'hFFFF, 16'd5, 16'd0, 16'hFFFE);
        sample(100); idle(2); sample(7); idle(3);
        sample(999); idle(1); sample(3);
        idle(5);
        check("signed_m71", 64'(dout), 64'hFFFF_FFB9);

        load_w(16'd1, 16'd1, 16'd1, 16'd1);
        for (int i = 0; i < 8; i++) sample(1);
        idle(5);
        check("b2b_4", 64'(dout), 64'd4);

        load_w(16'd1, 16'd2, 16'd3, 16'd4);
        sample(7); sample(9);
        step(0, '0, 1, 0, '0, '0);
        step(1, 32'd55, 1, 0, '0, '0);
        sample(10); sample(20); sample(30); sample(40);
        idle(5);
        check("clear_300", 64'(dout), 64'd300);

        sample(10);
        step(1, 32'd20, 0, 1, 2'd1, 16'd9);
        sample(30); sample(40);
        sample(10); sample(20); sample(30); sample(40);
        idle(5);
        check("collide_440", 64'(dout), 64'd440);

        load_w(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 4; i++) sample(32'hFFFF_FFFF);
        idle(5);
`ifdef DFR_READOUT_SAT_EN
        check("sat_max", 64'(dout), 64'h7FFF_FFFF);
`else
        check("wrap_trunc", 64'(dout), 64'hFFFE_0004);
`endif

        sample(5); sample(6);
        do_reset();
        idle(5);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                 ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 16'($urandom()));
            if (i == 300) do_reset();
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
